// File: rtl/wb_pkg.sv
// Shared definitions for the writeback port arbiter: control-bit positions
// in the MEM/WB control field and the arbiter FSM state encoding.
package wb_pkg;

    localparam int WB_CTRL_REGWRITE = 1;
    localparam int WB_CTRL_MEMTOREG = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage : wb_pkg

// File: rtl/wb_hold_buf.sv
// One-entry hold register for a multiply/divide result waiting for the
// register-file write port.
module wb_hold_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            clear,
    input  logic [4:0]      load_rd,
    input  logic [XLEN-1:0] load_data,
    output logic            buf_valid,
    output logic [4:0]      buf_rd,
    output logic [XLEN-1:0] buf_data
);

    // Load and clear are never asserted together; load is listed first so an
    // accidental overlap keeps the newer result rather than losing it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_rd    <= load_rd;
            buf_data  <= load_data;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end
    end

endmodule : wb_hold_buf

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between MEM/WB writeback
// and buffered MDU results, forcing a one-cycle stall when the MDU starves.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] wb_alu_out,
    input  logic [XLEN-1:0] wb_data_out,
    input  logic [4:0]      wb_rd,
    input  logic [1:0]      wb_ctrl,
    input  logic            mdu_valid,
    input  logic [4:0]      mdu_rd,
    input  logic [XLEN-1:0] mdu_result,
    output logic            mdu_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            stall_req
);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;

    logic            pipe_req;
    logic [XLEN-1:0] pipe_data;
    logic            accept;
    logic            buf_load;
    logic            grant_mdu;
    logic            buf_valid;
    logic [4:0]      buf_rd;
    logic [XLEN-1:0] buf_data;

    assign pipe_req  = wb_ctrl[WB_CTRL_REGWRITE] && (wb_rd != 5'd0);
    assign pipe_data = wb_ctrl[WB_CTRL_MEMTOREG] ? wb_data_out : wb_alu_out;

    assign mdu_ready = !buf_valid;
    assign accept    = mdu_valid && mdu_ready;
    // Results aimed at x0 are consumed but never occupy the buffer.
    assign buf_load  = accept && (mdu_rd != 5'd0);
    assign grant_mdu = buf_valid && (!pipe_req || (state == FORCE));
    assign stall_req = (state == FORCE);

    wb_hold_buf #(
        .XLEN(XLEN)
    ) u_hold_buf (
        .clk       (clk),
        .reset     (reset),
        .load      (buf_load),
        .clear     (grant_mdu),
        .load_rd   (mdu_rd),
        .load_data (mdu_result),
        .buf_valid (buf_valid),
        .buf_rd    (buf_rd),
        .buf_data  (buf_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        unique case (state)
            IDLE: begin
                if (buf_load) begin
                    state_next    = PEND;
                    wait_cnt_next = '0;
                end
            end
            PEND: begin
                if (grant_mdu) begin
                    state_next    = IDLE;
                    wait_cnt_next = '0;
                end else begin
                    if (wait_cnt != '1) begin
                        wait_cnt_next = wait_cnt + 1'b1;
                    end
                    if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                        state_next = FORCE;
                    end
                end
            end
            FORCE: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Reset gates the port directly so a pipeline request cannot write while
    // the arbiter is held in reset.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (reset) begin
            if (grant_mdu) begin
                rf_we    = 1'b1;
                rf_waddr = buf_rd;
                rf_wdata = buf_data;
            end else if (pipe_req && !stall_req) begin
                rf_we    = 1'b1;
                rf_waddr = wb_rd;
                rf_wdata = pipe_data;
            end
        end
    end

endmodule : wb_port_arbiter
